// File: rtl/onehot_encoder_if.sv
// Handshake bundle for onehot_encoder_pipe: request-vector input side and encoded-index output side.
// master = producer/consumer environment, slave = the encoder.
interface onehot_encoder_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    // A word moves on a side only in a cycle where valid && ready; valid never waits on ready,
    // and a raised out_valid keeps every out_* field stable until out_ready takes it.
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_index;
    logic         out_zero;
    logic         out_multi;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_zero, out_multi
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_zero, out_multi
    );
endinterface

// File: rtl/onehot_encoder_pipe.sv
// Registered N-to-log2(N) encoder, strict one-hot (MODE=0) or MSB-priority (MODE=1), with zero/multi flags.
// Define ENC_ERR_CNT_EN to add the saturating error counter (err_count/err_clr ports).
module onehot_encoder_pipe #(
    parameter int N         = 8,
    parameter int MODE      = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ENC_ERR_CNT_EN
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count,
`endif
    onehot_encoder_if.slave      bus
);
    localparam int W = $clog2(N);

    if (N < 2 || ERR_CNT_W < 1) begin : g_bad_param
        $error("onehot_encoder_pipe: N must be >= 2 and ERR_CNT_W >= 1");
    end

    logic         valid_q;
    logic [W-1:0] index_q;
    logic         zero_q;
    logic         multi_q;

    logic         seen;
    logic         many;
    logic [W-1:0] hi_pos;
    logic [W-1:0] enc_index;
    logic         enc_err;
    logic         accept;

    // Scan low to high so the last set bit seen is the highest; a second hit marks multi-hot.
    always_comb begin
        seen   = 1'b0;
        many   = 1'b0;
        hi_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.in_data[i]) begin
                many   = many | seen;
                seen   = 1'b1;
                hi_pos = W'(i);
            end
        end
    end

    always_comb begin
        enc_index = hi_pos;
        if (!seen || (many && MODE == 0)) begin
            enc_index = '0;
        end
        enc_err = !seen || (many && MODE == 0);
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            index_q <= '0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            index_q <= enc_index;
            zero_q  <= !seen;
            multi_q <= many;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_index = index_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_multi = multi_q;

`ifdef ENC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_q;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_q <= '0;
        end else if (accept && enc_err && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err;
    assign unused_err = enc_err;
`endif
endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: three instances (N=8/MODE=0, N=8/MODE=1, N=5/MODE=1) share one
// stimulus stream; a reference model is compared every cycle and directed literals pin key results.
module tb_onehot_encoder_pipe;
    localparam int ND = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;
    bit         chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    onehot_encoder_if #(.N(8)) if0 ();
    onehot_encoder_if #(.N(8)) if1 ();
    onehot_encoder_if #(.N(5)) if2 ();

    assign if0.in_valid  = in_valid;
    assign if1.in_valid  = in_valid;
    assign if2.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if1.in_data   = in_data;
    assign if2.in_data   = in_data[4:0];
    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;
    assign if2.out_ready = out_ready;

`ifdef ENC_ERR_CNT_EN
    logic [1:0] err0, err1, err2;
    onehot_encoder_pipe #(.N(8), .MODE(0), .ERR_CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .err_clr(err_clr), .err_count(err0), .bus(if0));
    onehot_encoder_pipe #(.N(8), .MODE(1), .ERR_CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .err_clr(err_clr), .err_count(err1), .bus(if1));
    onehot_encoder_pipe #(.N(5), .MODE(1), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .err_clr(err_clr), .err_count(err2), .bus(if2));
`else
    onehot_encoder_pipe #(.N(8), .MODE(0), .ERR_CNT_W(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    onehot_encoder_pipe #(.N(8), .MODE(1), .ERR_CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    onehot_encoder_pipe #(.N(5), .MODE(1), .ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
`endif

    logic       dv_ready[ND];
    logic       dv_valid[ND];
    logic [2:0] dv_idx[ND];
    logic       dv_zero[ND];
    logic       dv_multi[ND];
    logic [1:0] dv_err[ND];

    assign dv_ready[0] = if0.in_ready;  assign dv_ready[1] = if1.in_ready;  assign dv_ready[2] = if2.in_ready;
    assign dv_valid[0] = if0.out_valid; assign dv_valid[1] = if1.out_valid; assign dv_valid[2] = if2.out_valid;
    assign dv_idx[0]   = if0.out_index; assign dv_idx[1]   = if1.out_index; assign dv_idx[2]   = if2.out_index;
    assign dv_zero[0]  = if0.out_zero;  assign dv_zero[1]  = if1.out_zero;  assign dv_zero[2]  = if2.out_zero;
    assign dv_multi[0] = if0.out_multi; assign dv_multi[1] = if1.out_multi; assign dv_multi[2] = if2.out_multi;
`ifdef ENC_ERR_CNT_EN
    assign dv_err[0] = err0; assign dv_err[1] = err1; assign dv_err[2] = err2;
`else
    assign dv_err[0] = 2'd0; assign dv_err[1] = 2'd0; assign dv_err[2] = 2'd0;
`endif

    // Reference model: per-instance width/mode and the result currently held at the output.
    int n_of[ND]    = '{8, 8, 5};
    int mode_of[ND] = '{0, 1, 1};
    bit m_valid[ND];
    int m_idx[ND];
    bit m_zero[ND];
    bit m_multi[ND];
    int m_err[ND];

    // Returns {err, multi, zero, index[2:0]} from popcount and floor(log2) of the masked vector.
    function automatic logic [5:0] encode(input logic [7:0] d, input int n, input int mode);
        int   m, p, hi;
        logic e, z, mu;
        logic [2:0] idx;
        m  = int'(d) & ((1 << n) - 1);
        p  = $countones(m);
        hi = (m == 0) ? 0 : $clog2(m + 1) - 1;
        z  = (p == 0);
        mu = (p > 1);
        idx = (p == 1 || (p > 1 && mode == 1)) ? 3'(hi) : 3'd0;
        e  = z || (mu && mode == 0);
        return {e, mu, z, idx};
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            logic [5:0] r;
            bit acc;
            r   = encode(in_data, n_of[d], mode_of[d]);
            acc = in_valid && (!m_valid[d] || out_ready);
            if (rst) begin
                m_valid[d] <= 1'b0;
                m_idx[d]   <= 0;
                m_zero[d]  <= 1'b0;
                m_multi[d] <= 1'b0;
            end else if (acc) begin
                m_valid[d] <= 1'b1;
                m_idx[d]   <= int'(r[2:0]);
                m_zero[d]  <= r[3];
                m_multi[d] <= r[4];
            end else if (out_ready) begin
                m_valid[d] <= 1'b0;
            end
            if (rst || err_clr)           m_err[d] <= 0;
            else if (acc && r[5])         m_err[d] <= (m_err[d] < 3) ? m_err[d] + 1 : 3;
        end
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                chk("model_in_ready", d, 32'(dv_ready[d]), 32'(!m_valid[d] || out_ready));
                chk("model_out_valid", d, 32'(dv_valid[d]), 32'(m_valid[d]));
                if (m_valid[d]) begin
                    chk("model_out_index", d, 32'(dv_idx[d]), 32'(m_idx[d]));
                    chk("model_out_zero", d, 32'(dv_zero[d]), 32'(m_zero[d]));
                    chk("model_out_multi", d, 32'(dv_multi[d]), 32'(m_multi[d]));
                end
`ifdef ENC_ERR_CNT_EN
                chk("model_err_count", d, 32'(dv_err[d]), 32'(m_err[d]));
`endif
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
    endtask

    initial begin
        // Reset for two cycles with the consumer stalled: in_ready must still be high.
        rst = 1'b1;
        out_ready = 1'b0;
        cycle();
        chk_en = 1'b1;
        cycle();
        for (int d = 0; d < ND; d++) begin
            chk("rst_out_valid", d, 32'(dv_valid[d]), 32'd0);
            chk("rst_out_index", d, 32'(dv_idx[d]), 32'd0);
            chk("rst_flags", d, 32'({dv_zero[d], dv_multi[d]}), 32'd0);
            chk("rst_in_ready", d, 32'(dv_ready[d]), 32'd1);
        end
        rst = 1'b0;

        // Walking one, back-to-back with out_ready high.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(8'(1 << k));
            chk("walk_valid", 0, 32'(if0.out_valid), 32'd1);
            chk("walk_index", 0, 32'(if0.out_index), 32'(k));
            chk("walk_flags", 0, 32'({if0.out_zero, if0.out_multi}), 32'd0);
        end

        // Zero and multi-hot vectors.
        send(8'h00);
        chk("zero_index", 0, 32'(if0.out_index), 32'd0);
        chk("zero_flag", 0, 32'(if0.out_zero), 32'd1);
        chk("zero_flag", 1, 32'(if1.out_zero), 32'd1);
        send(8'h24);
        chk("multi_strict_index", 0, 32'(if0.out_index), 32'd0);
        chk("multi_strict_flag", 0, 32'(if0.out_multi), 32'd1);
        chk("multi_prio_index", 1, 32'(if1.out_index), 32'd5);
        chk("multi_prio_flag", 1, 32'(if1.out_multi), 32'd1);
        chk("n5_single_index", 2, 32'(if2.out_index), 32'd2);

        // Drain, then stall a held result while in_data churns.
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b0;
        send(8'h10);
        for (int k = 0; k < 5; k++) begin
            in_data = 8'($urandom_range(0, 255));
            cycle();
            chk("stall_index", 0, 32'(if0.out_index), 32'd4);
            chk("stall_valid", 0, 32'(if0.out_valid), 32'd1);
            chk("stall_in_ready", 0, 32'(if0.in_ready), 32'd0);
            chk("stall_index", 2, 32'(if2.out_index), 32'd4);
        end
        out_ready = 1'b1;
        send(8'h08);
        chk("release_index", 0, 32'(if0.out_index), 32'd3);
        chk("release_valid", 0, 32'(if0.out_valid), 32'd1);
        in_valid = 1'b0;
        cycle();
        chk("release_drained", 0, 32'(if0.out_valid), 32'd0);

`ifdef ENC_ERR_CNT_EN
        // Saturating 2-bit error counter, then clear racing an error word.
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(8'h00);
            chk("err_count_sat", 0, 32'(err0), 32'((k < 2) ? k + 1 : 3));
        end
        err_clr = 1'b1;
        send(8'h00);
        chk("err_clr_wins", 0, 32'(err0), 32'd0);
        chk("err_clr_wins", 2, 32'(err2), 32'd0);
        err_clr = 1'b0;
        send(8'h24);
        chk("err_strict_multi", 0, 32'(err0), 32'd1);
        chk("err_prio_multi_ok", 1, 32'(err1), 32'd0);
`endif

        // N=5 priority vector, then reset while a result is stalled.
        send(8'h16);
        chk("n5_prio_index", 2, 32'(if2.out_index), 32'd4);
        chk("n5_prio_multi", 2, 32'(if2.out_multi), 32'd1);
        out_ready = 1'b0;
        send(8'h04);
        chk("held_before_rst", 2, 32'(if2.out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int d = 0; d < ND; d++) chk("rst_discard_valid", d, 32'(dv_valid[d]), 32'd0);
        out_ready = 1'b1;
        cycle();
        for (int d = 0; d < ND; d++) chk("rst_never_delivered", d, 32'(dv_valid[d]), 32'd0);

        repeat (3) cycle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
